// File: rtl/lsu_mem_master_if.sv
// Bundles the request, response and memory-port signals of the load/store initiator.
// The master modport is the LSU's view of the bundle. The slave modport is the view of the
// environment, meaning the issuing core together with the data memory.
interface lsu_mem_master_if #(
    parameter int XLEN = 32
) ();
    // Request channel: the core presents a request and the LSU takes it.
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    // Response channel: the LSU presents a completion and the core takes it.
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    // Word-wide memory port with no byte enables.
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_write_data;
    logic            mem_write_enable;
    logic            mem_read_enable;
    logic [XLEN-1:0] mem_read_data;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_address, mem_write_data, mem_write_enable, mem_read_enable,
        input  mem_read_data
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_address, mem_write_data, mem_write_enable, mem_read_enable,
        output mem_read_data
    );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for a word-wide memory that has no byte enables.
// It handles one request at a time.
// - Loads read the word, then extract the byte or half and extend it.
// - SW writes the word directly.
// - SB and SH do a read-modify-write: read the word, merge the new bytes, write it back.
// Optional macro LSU_MISALIGN_CHECK_EN: when defined, a misaligned H or W access is refused
// with rsp_err and makes no memory access. When undefined, misalignment is ignored and the
// low address bits below the access size are dropped.
module lsu_mem_master #(
    parameter int XLEN       = 32,
    parameter bit WORD_INDEX = 1'b1   // 1: mem_address is a word index, 0: word-aligned byte address
) (
    input  logic             clk,
    input  logic             reset,
    lsu_mem_master_if.master bus
);

    // The lane logic below assumes four byte lanes, so XLEN is expected to be 32.
    localparam int NLANES = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // Request captured at accept. Only the low half of the store data is kept: SW bypasses
    // this register, and B/H stores only ever use bits [15:0].
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [15:0]     r_wdata_lo;

    // Registered outputs. They hold their values between the states that update them.
    logic [XLEN-1:0] r_mem_wdata;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_err;

    logic            w_funct3_legal;
    logic            w_illegal;
    logic            w_misaligned;
    logic            w_reject;
    logic            w_is_sw;

    logic [7:0]      w_rd_byte [NLANES];
    logic [NLANES-1:0] w_lane_sel;
    logic [XLEN-1:0] w_merge_word;
    logic [7:0]      w_ld_byte;
    logic [15:0]     w_ld_half;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_mem_address;

    // ------------------------------------------------------------------
    // Request classification. This looks at the live request, because the
    // decision is taken in IDLE on the accept edge.
    // ------------------------------------------------------------------
    assign w_funct3_legal = (bus.req_funct3 == F3_B)  || (bus.req_funct3 == F3_H) ||
                            (bus.req_funct3 == F3_W)  || (bus.req_funct3 == F3_BU) ||
                            (bus.req_funct3 == F3_HU);

    // Unsigned variants do not exist for stores.
    assign w_illegal = !w_funct3_legal || (bus.req_we && bus.req_funct3[2]);

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misaligned = (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && bus.req_addr[0]) ||
                          ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // A rejected request skips the memory entirely and answers straight away.
    assign w_reject = w_illegal || w_misaligned;
    assign w_is_sw  = bus.req_we && (bus.req_funct3 == F3_W);

    // ------------------------------------------------------------------
    // Byte-lane datapath on the word returned by memory.
    // For each lane, decide whether the store replaces it, and split out the read byte.
    // SB writes the low store byte into its single lane. SH writes the low store half
    // across the two lanes of the selected half.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            assign w_rd_byte[gi]  = bus.mem_read_data[8*gi +: 8];
            assign w_lane_sel[gi] = ((r_funct3 == F3_B) && (r_addr[1:0] == 2'(gi))) ||
                                    ((r_funct3 == F3_H) && (r_addr[1]   == 1'(gi / 2)));
            assign w_merge_word[8*gi +: 8] = !w_lane_sel[gi]      ? w_rd_byte[gi]     :
                                             (r_funct3 == F3_B)   ? r_wdata_lo[7:0]   :
                                                                    r_wdata_lo[8*(gi % 2) +: 8];
        end
    endgenerate

    assign w_ld_byte = w_rd_byte[r_addr[1:0]];
    assign w_ld_half = r_addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

    // Extend the selected byte or half according to the load flavour.
    always_comb begin
        w_load_data = '0;
        case (r_funct3)
            F3_B:    w_load_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
            F3_H:    w_load_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
            F3_W:    w_load_data = bus.mem_read_data;
            F3_BU:   w_load_data = {{(XLEN-8){1'b0}}, w_ld_byte};
            F3_HU:   w_load_data = {{(XLEN-16){1'b0}}, w_ld_half};
            default: w_load_data = '0;
        endcase
    end

    // The address comes from the latched request. It therefore stays stable from READ
    // through WRITE, whatever the core does to req_addr in the meantime.
    generate
        if (WORD_INDEX) begin : g_word_index
            assign w_mem_address = {2'b00, r_addr[XLEN-1:2]};
        end else begin : g_byte_address
            assign w_mem_address = {r_addr[XLEN-1:2], 2'b00};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register. Reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decision for each request class.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (w_reject) begin
                        w_state_next = ST_RESP;
                    end else if (w_is_sw) begin
                        w_state_next = ST_WRITE;
                    end else begin
                        w_state_next = ST_READ;
                    end
                end
            end
            ST_READ:    w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE:   w_state_next = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Outputs. The strobes decode straight from the state, so each one lasts exactly one
    // cycle, and they can never both be high at once.
    always_comb begin
        bus.req_ready        = (r_state == ST_IDLE);
        bus.rsp_valid        = (r_state == ST_RESP);
        bus.rsp_rdata        = r_rsp_rdata;
        bus.rsp_err          = r_rsp_err;
        bus.mem_read_enable  = (r_state == ST_READ);
        bus.mem_write_enable = (r_state == ST_WRITE);
        bus.mem_address      = w_mem_address;
        bus.mem_write_data   = r_mem_wdata;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Latch the request on accept. In CAPTURE, fold the returned word into either the load
    // result or the merged store word. The read word is consumed in the same cycle it
    // arrives, so r_mem_wdata doubles as the capture buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_wdata_lo  <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_funct3    <= bus.req_funct3;
                        r_addr      <= bus.req_addr;
                        r_wdata_lo  <= bus.req_wdata[15:0];
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= w_reject;
                        if (w_is_sw) begin
                            r_mem_wdata <= bus.req_wdata;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (r_we) begin
                        r_mem_wdata <= w_merge_word;
                    end else begin
                        r_rsp_rdata <= w_load_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master.
// - The bench owns a 16-word memory that answers the DUT's port.
// - A reference model computes each request's expected result and cycle timing from the
//   architectural rules: lane arithmetic, a shadow memory array and the latency table.
// - One negedge compare process checks the DUT outputs on every cycle.
// - A few literal values pin the model's results for the directed cases.
`timescale 1ns/1ps
module tb_lsu_mem_master;

    localparam int XLEN = 32;
    localparam bit WI   = 1'b1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.XLEN(XLEN)) bus ();

    lsu_mem_master #(.XLEN(XLEN), .WORD_INDEX(WI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Bench memory. Reads are registered, so data appears the cycle after mem_read_enable.
    logic [31:0] bmem [16];
    function automatic int mem_idx(input logic [31:0] a);
        return WI ? int'(a[3:0]) : int'(a[5:2]);
    endfunction
    always @(posedge clk) begin
        if (bus.mem_write_enable) bmem[mem_idx(bus.mem_address)] <= bus.mem_write_data;
        if (bus.mem_read_enable)  bus.mem_read_data <= bmem[mem_idx(bus.mem_address)];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: the shadow memory and the expectations for the request in flight.
    logic [31:0] model_mem [16];
    bit          tx_active = 1'b0;
    int          tx_id = 0;
    int          tx_acc, tx_rd_at, tx_wr_at, tx_resp_at, tx_last_strobe;
    logic [31:0] tx_maddr, tx_wdata, tx_rdata;
    logic        tx_err;
    bit          pend_write;
    int          pend_idx;
    logic [31:0] pend_word;

    // Results recorded by the compare process at each response handshake.
    int          closed_id = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    int n_chk_d = 0, n_pass_d = 0;   // driver-side checks
    int n_chk_c = 0, n_pass_c = 0;   // per-cycle compare checks

    task automatic chk_d(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk_d++;
        if (act === exp) n_pass_d++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic chk_c(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk_c++;
        if (act === exp) n_pass_c++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d, tx %0d)", nm, act, exp, cyc, tx_id);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic e;
        e = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (we && f3 >= 3'b100);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) e = 1'b1;
        if (f3 == 3'b010 && a[1:0] != 2'b00) e = 1'b1;
`else
        if (a[0] === 1'bx) e = 1'bx;   // address does not affect legality here
`endif
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128)   ? b - 32'd256   : b;   // wrap gives sign extension
            3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [31:0] a, input logic [31:0] d);
        int sh;
        case (f3)
            3'b000: begin sh = 8 * a[1:0];  return (w & ~(32'hFF << sh))   | ((d & 32'hFF) << sh);   end
            3'b001: begin sh = 16 * a[1];   return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh); end
            default: return d;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Drives a request, then records what the model expects once it is accepted.
    // Returns with cyc equal to the accept edge.
    task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, output bit ok);
        logic        err;
        logic [31:0] old;
        int          guard, acc;
        err = model_err(we, f3, a);
        old = model_mem[a[5:2]];
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.rsp_ready  = 1'b0;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk_d("accept_ready", {31'd0, bus.req_ready}, 32'd1);
        ok = (bus.req_ready === 1'b1);
        if (!ok) begin
            bus.req_valid = 1'b0;
            return;
        end
        acc        = cyc + 1;
        tx_rd_at   = -1;
        tx_wr_at   = -1;
        tx_rdata   = 32'd0;
        tx_wdata   = 32'd0;
        tx_err     = err;
        tx_maddr   = WI ? (a >> 2) : (a & ~32'd3);
        if (err) begin
            tx_resp_at = acc;
        end else if (!we) begin
            tx_rd_at = acc; tx_resp_at = acc + 2; tx_rdata = model_load(old, f3, a);
        end else if (f3 == 3'b010) begin
            tx_wr_at = acc; tx_resp_at = acc + 1; tx_wdata = d;
        end else begin
            tx_rd_at = acc; tx_wr_at = acc + 2; tx_resp_at = acc + 3; tx_wdata = model_store(old, f3, a, d);
        end
        tx_last_strobe = (tx_wr_at > tx_rd_at) ? tx_wr_at : tx_rd_at;
        pend_write = we && !err;
        pend_idx   = int'(a[5:2]);
        pend_word  = tx_wdata;
        tx_acc     = acc;
        tx_id      = tx_id + 1;
        tx_active  = 1'b1;
        @(posedge clk); #1;
        // Scramble the request lines: the DUT must be working from its latched copy.
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    // Holds rsp_ready low for 'hold' cycles of the response, then waits for the handshake.
    task automatic finish_req(input int hold);
        int guard;
        guard = 0;
        while (closed_id != tx_id && guard < 64) begin
            bus.rsp_ready = (cyc >= tx_resp_at + hold);
            @(posedge clk); #1; guard++;
        end
        chk_d("completion", {31'd0, closed_id == tx_id}, 32'd1);
        if (closed_id == tx_id && pend_write) model_mem[pend_idx] = pend_word;
        tx_active     = 1'b0;
        bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int hold);
        bit ok;
        start_req(we, f3, a, d, ok);
        if (ok) finish_req(hold);
    endtask

    function automatic logic [2:0] pick_f3(input int unsigned r);
        case (r)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b100;
            4: return 3'b101;
            5: return 3'b011;
            6: return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            // Outputs are only meaningful once reset is released.
        end else if (!tx_active || cyc < tx_acc || closed_id == tx_id) begin
            chk_c("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
            chk_c("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk_c("idle_strobes", {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
        end else begin
            chk_c("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk_c("read_strobe",  {31'd0, bus.mem_read_enable},  {31'd0, cyc == tx_rd_at});
            chk_c("write_strobe", {31'd0, bus.mem_write_enable}, {31'd0, cyc == tx_wr_at});
            if (!tx_err && cyc <= tx_last_strobe) chk_c("mem_address", bus.mem_address, tx_maddr);
            if (bus.mem_write_enable) chk_c("mem_write_data", bus.mem_write_data, tx_wdata);
            if (cyc >= tx_resp_at) begin
                chk_c("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
                chk_c("rsp_rdata", bus.rsp_rdata, tx_rdata);
                chk_c("rsp_err", {31'd0, bus.rsp_err}, {31'd0, tx_err});
                if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                    last_rdata = bus.rsp_rdata;
                    last_err   = bus.rsp_err;
                    closed_id  = tx_id;
                end
            end else begin
                chk_c("rsp_valid_early", {31'd0, bus.rsp_valid}, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          ok;
        logic [2:0]  f3;
        logic        we;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_d("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk_d("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk_d("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk_d("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk_d("reset_strobes", {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
        chk_d("reset_mem_address", bus.mem_address, 32'd0);
        chk_d("reset_mem_write_data", bus.mem_write_data, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // SW then LW of word 0, and fill the rest of memory through the DUT.
        run(1'b1, 3'b010, 32'h0, 32'hABCDEF01, 0);
        for (int i = 1; i < 16; i++) run(1'b1, 3'b010, 32'(i * 4), $urandom, $urandom_range(0, 2));
        run(1'b0, 3'b010, 32'h0, 32'h0, 0);
        chk_d("lw_word0", last_rdata, 32'hABCDEF01);
        chk_d("lw_word0_err", {31'd0, last_err}, 32'd0);

        // Sub-word loads with sign and zero extension.
        run(1'b0, 3'b000, 32'h1, 32'h0, 0); chk_d("lb_addr1",  last_rdata, 32'hFFFFFFEF);
        run(1'b0, 3'b100, 32'h1, 32'h0, 1); chk_d("lbu_addr1", last_rdata, 32'h000000EF);
        run(1'b0, 3'b001, 32'h2, 32'h0, 0); chk_d("lh_addr2",  last_rdata, 32'hFFFFABCD);
        run(1'b0, 3'b101, 32'h2, 32'h0, 2); chk_d("lhu_addr2", last_rdata, 32'h0000ABCD);

        // Read-modify-write stores.
        run(1'b1, 3'b000, 32'h2, 32'hFFFFFF55, 0);
        run(1'b0, 3'b010, 32'h0, 32'h0, 0); chk_d("sb_merge", last_rdata, 32'hAB55EF01);
        run(1'b1, 3'b001, 32'h0, 32'hEEEE1234, 0);
        run(1'b0, 3'b010, 32'h0, 32'h0, 0); chk_d("sh_merge", last_rdata, 32'hAB551234);

        // Response held off for five cycles.
        run(1'b0, 3'b010, 32'h0, 32'h0, 5); chk_d("backpressure_lw", last_rdata, 32'hAB551234);

        // Illegal funct3, then a misaligned word load.
        run(1'b0, 3'b111, 32'h0, 32'h0, 0);
        chk_d("illegal_err", {31'd0, last_err}, 32'd1);
        chk_d("illegal_rdata", last_rdata, 32'd0);
        run(1'b0, 3'b010, 32'h2, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk_d("misaligned_lw_err", {31'd0, last_err}, 32'd1);
        chk_d("misaligned_lw_rdata", last_rdata, 32'd0);
`else
        chk_d("misaligned_lw_err", {31'd0, last_err}, 32'd0);
        chk_d("misaligned_lw_rdata", last_rdata, 32'hAB551234);
`endif

        // Random traffic: mixed loads and stores, occasional illegal funct3, random
        // backpressure and random idle gaps between requests.
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? pick_f3($urandom_range(5, 7)) : pick_f3($urandom_range(0, 4));
            run(we, f3, $urandom, $urandom, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Reset asserted while an SB is in CAPTURE. No write may follow.
        start_req(1'b1, 3'b000, 32'h9, 32'h000000A5, ok);
        if (ok) begin
            @(posedge clk); #1;          // now in CAPTURE
            reset = 1'b1;
            @(posedge clk); #1;
            reset     = 1'b0;
            tx_active = 1'b0;
            chk_d("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
            chk_d("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk_d("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk_d("abort_mem_write_data", bus.mem_write_data, 32'd0);
            repeat (4) begin @(posedge clk); #1; end
        end
        run(1'b0, 3'b010, 32'h8, 32'h0, 0);
        chk_d("abort_word_intact", last_rdata, model_mem[2]);

        // The bench memory must hold exactly the shadow memory's contents.
        for (int i = 0; i < 16; i++) chk_d("mem_contents", bmem[i], model_mem[i]);

        $display("%0d/%0d checks passed", n_pass_d + n_pass_c, n_chk_d + n_chk_c);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-wide data memory port (address, write_data, write_enable, read_enable, read_data) on behalf of the core.
- Accepts one RV32I load/store request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Performs byte/halfword extraction with sign or zero extension.
- Memory has no byte enables, so sub-word stores are done as read-modify-write.

Parameters:
- XLEN, 32, data and address width.
- WORD_INDEX, 1: 1 drives mem_address = req_addr>>2 (word index); 0 drives {req_addr[31:2],2'b00}.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, can accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data (low bits used for B/H).
- rsp_valid  out  1  response/completion present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  XLEN  extended load data (0 for stores).
- rsp_err  out  1  misaligned/illegal funct3 (feature-dependent).
- mem_address  out  XLEN  to memory.
- mem_write_data  out  XLEN  to memory.
- mem_write_enable  out  1  one-cycle write strobe.
- mem_read_enable  out  1  one-cycle read strobe.
- mem_read_data  in  XLEN  valid the cycle after mem_read_enable.

Behaviour:
- Reset (sync, high): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_*_enable=0; mem_address=0; mem_write_data=0. Reset mid-transaction aborts it; no further mem strobes.
- Handshake: accept when req_valid&req_ready in IDLE; latch we, funct3, addr, wdata. req_ready=1 only in IDLE.
- States:
  - IDLE: waits for an accepted request, then goes to READ (load, SB, SH) or WRITE (SW).
  - READ: mem_read_enable=1, mem_address driven.
  - CAPTURE: latch mem_read_data into buffer; loads go to RESP, sub-word stores go to WRITE.
  - WRITE: mem_write_enable=1, mem_write_data = merged word.
  - RESP: rsp_valid=1; holds until rsp_ready, then goes to IDLE. rsp_valid stays 1 and rsp_rdata/rsp_err stay stable while rsp_ready=0.
- Latency, accept at edge T:
  - loads: READ T+1, CAPTURE T+2, RESP T+3.
  - SW: WRITE T+1, RESP T+2.
  - SB/SH: READ T+1, CAPTURE T+2, WRITE T+3, RESP T+4.
- Strobes: exactly one read and/or one write strobe per request; never both in one cycle. mem_address is stable from READ through WRITE.
- Load extract: byte lane = addr[1:0], half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store merge: SB replaces byte addr[1:0] with wdata[7:0]; SH replaces half addr[1] with wdata[15:0]; the other bytes come from the captured word.
- Illegal funct3 (011, 110, 111; or 1xx on store): no memory access. IDLE goes to RESP next cycle with rsp_err=1, rsp_rdata=0.
- Back-to-back: a new request can be accepted the cycle after the RESP handshake (IDLE).

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: H with addr[0]=1, or W with addr[1:0]≠0, makes no memory access; IDLE goes to RESP with rsp_err=1, rsp_rdata=0.
- Undefined: misalignment is ignored. W uses the word at addr[31:2]. H uses the half selected by addr[1] (addr[0] ignored). rsp_err only for illegal funct3.

Test Plan:
1. SW addr 0x0, wdata 0xABCDEF01 → one mem_write_enable cycle at T+1, mem_address 0, mem_write_data 0xABCDEF01. Then LW addr 0 → rsp_rdata 0xABCDEF01 at T+3, rsp_err 0.
2. Word 0 = 0xABCDEF01; LB addr 1 → 0xFFFFFFEF; LBU addr 1 → 0x000000EF; LH addr 2 → 0xFFFFABCD; LHU addr 2 → 0x0000ABCD.
3. Word 0 = 0xABCDEF01; SB addr 2, wdata 0x55 → read then write 0xAB55EF01 at T+3. SH addr 0, wdata 0x1234 → write 0xAB551234.
4. Response backpressure: rsp_ready low for 5 cycles on LW → rsp_valid and rsp_rdata held, req_ready 0, no extra mem strobes; released in IDLE next cycle.
5. Illegal funct3 3'b111 load → rsp_err 1 at T+1, no mem strobes. With LSU_MISALIGN_CHECK_EN: LW addr 0x2 → rsp_err 1, no access. Without it: LW addr 0x2 → word 0 returned, rsp_err 0.
6. Reset asserted in CAPTURE of an SB → next cycle IDLE, req_ready 1, rsp_valid 0, no mem_write_enable ever issued.
